// File: rtl/arbiter4_rr_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arbiter4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int         N_REQ      = 4;
    localparam int         IDX_W      = 2;
    localparam logic [1:0] LAST_RESET = 2'd3;

endpackage

// File: rtl/arbiter4_rr_if.sv
// Request/grant bundle between requesters and arbiter4_rr.
// 'release' is a language keyword, so the release strobe is named 'rel'.
interface arbiter4_rr_if;
    import arbiter4_pkg::*;

    logic [N_REQ-1:0] req;
    logic             rel;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output req, rel,
        input  grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, rel,
        output grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/arbiter4_rr_pick4.sv
// Circular first-set-bit search starting at last+1; with i_exclude_en the
// requester at 'last' is skipped entirely instead of getting lowest priority.
module rr_pick4
    import arbiter4_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    input  logic             i_exclude_en,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    always_comb begin
        logic [IDX_W-1:0] w_idx;
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = i_last + IDX_W'(i);
            if (!o_any && i_req[w_idx] && !(i_exclude_en && (i == N_REQ))) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/arbiter4_rr.sv
// Round-robin arbiter, registered grant index/valid, grant held until release.
// Optional forced revocation after MAX_HOLD cycles: define ARB4_HOLD_TIMEOUT_EN.
module arbiter4_rr
    import arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic           CLK,
    input  logic           ASYNCRESETN,
    arbiter4_rr_if.slave   bus
);

    arb_state_t       r_state, w_nxt_state;
    logic [IDX_W-1:0] r_last, w_nxt_last;
    logic [IDX_W-1:0] r_grant_idx, w_nxt_idx;
    logic             r_valid, w_nxt_valid;
    logic             w_new_grant;
    logic             w_tmo;
    logic             w_handoff;
    logic [IDX_W-1:0] w_pick_last;
    logic [IDX_W-1:0] w_winner;
    logic             w_any;

    // In GRANT the search starts after the owner and skips it; the owner
    // re-grant fallback is handled below.
    assign w_pick_last = (r_state == GRANT) ? r_grant_idx : r_last;

    rr_pick4 u_pick (
        .i_req        (bus.req),
        .i_last       (w_pick_last),
        .i_exclude_en (r_state == GRANT),
        .o_winner     (w_winner),
        .o_any        (w_any)
    );

`ifdef ARB4_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    // Fires on the edge that ends the MAX_HOLD-th held cycle; release wins.
    assign w_tmo = (r_state == GRANT) && !bus.rel &&
                   (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if (w_new_grant || (w_nxt_state == IDLE))
                r_hold_cnt <= '0;
            else if ((r_state == GRANT) && !bus.rel && (r_hold_cnt != CNT_W'(MAX_HOLD)))
                r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic [7:0] w_unused_hold;

    assign w_unused_hold = 8'(MAX_HOLD);
    assign w_tmo         = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    assign w_handoff = (r_state == GRANT) && (bus.rel || w_tmo);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_last  = r_last;
        w_nxt_idx   = r_grant_idx;
        w_nxt_valid = r_valid;
        w_new_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nxt_state = GRANT;
                    w_nxt_idx   = w_winner;
                    w_nxt_valid = 1'b1;
                    w_new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (w_handoff) begin
                    w_nxt_last = r_grant_idx;
                    if (w_any) begin
                        w_nxt_idx   = w_winner;
                        w_new_grant = 1'b1;
                    end else if (bus.req[r_grant_idx]) begin
                        w_new_grant = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_valid = 1'b0;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state     <= IDLE;
            r_last      <= LAST_RESET;
            r_grant_idx <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_last      <= w_nxt_last;
            r_grant_idx <= w_nxt_idx;
            r_valid     <= w_nxt_valid;
        end
    end

    assign bus.grant_idx   = r_grant_idx;
    assign bus.grant_valid = r_valid;

endmodule
